tt_sweeper: RTL
===============

Name: tt_sweeper

Overview:
Parametrised sequential truth-table generator for an N-input Boolean function defined by a minterm mask.
- On start, a counter sweeps every input combination 0..2^N-1, one per enabled cycle, and emits the input vector with the function value.
- Keeps a running count of true minterms and signals completion.
- Used as a self-checking function source and table printer for the combinational exercise blocks; replaces hand-written per-function stimulus sequences.

Parameters:
- N_IN, 3, number of function inputs (1..8).
- MASK_RST, 8'h42, reset value of the minterm mask, width 2^N_IN; bit i = f at input index i.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin sweep; sampled only in IDLE
- load  in  1  load mask_in into mask register; sampled only in IDLE
- mask_in  in  2^N_IN  new minterm mask
- step_en  in  1  advance enable in RUN; low = hold (pause)
- idx  out  N_IN  index of current table row
- x_vec  out  N_IN  input vector of current row (MSB = first input)
- f  out  1  function value of current row
- valid  out  1  idx/x_vec/f valid this cycle
- busy  out  1  sweep in progress (RUN or DONE)
- done  out  1  one-cycle end-of-sweep pulse
- ones_cnt  out  N_IN+1  number of rows with f=1 in current/last sweep

Behaviour:
- Reset values: state IDLE, ptr=0, mask=MASK_RST, idx=0, x_vec=0, f=0, valid=0, busy=0, done=0, ones_cnt=0.
- Reset is asynchronous and takes effect immediately, including mid-sweep; the sweep is abandoned and no done pulse is generated.
- All outputs are registered.
- IDLE:
  - load=1: mask<=mask_in.
  - start=1: state<=RUN, ptr<=0, ones_cnt<=0, busy<=1.
  - load and start together: the new mask is loaded and the sweep uses it (load takes priority in the same edge).
- RUN, step_en=1, each edge:
  - valid<=1, idx<=ptr, x_vec<=ptr, f<=mask[ptr].
  - ones_cnt<=ones_cnt+mask[ptr].
  - ptr<=ptr+1.
  - If ptr==2^N_IN-1: state<=DONE and ptr wraps to 0.
- RUN, step_en=0: valid<=0; idx/x_vec/f/ptr/ones_cnt hold.
- RUN ignores start and load: the mask is frozen for the whole sweep.
- DONE (one cycle): valid<=0, done<=1, state<=IDLE; busy<=0 on the same edge. done returns to 0 on the following edge.
- Latency with start high at edge k and step_en constantly high:
  - Rows 0..2^N-1 valid at edges k+1..k+2^N.
  - done high after edge k+2^N+1 for one cycle.
  - busy high from edge k to edge k+2^N+1.
- ones_cnt width N_IN+1 holds the maximum value 2^N_IN without overflow. It keeps its value after done until the next start.
- idx/x_vec/f keep the last row after the sweep ends; only valid marks them meaningful.

Optional Feature:
- Macro: TT_AUTOREPEAT_EN.
- With the macro: extra input port repeat_en (1 bit).
  - If repeat_en=1 in DONE: done still pulses, state<=RUN, ptr<=0, ones_cnt<=0, busy stays 1, and the next row 0 is valid one edge later.
  - load stays ignored across repeats.
- Without the macro: no repeat_en port; DONE always returns to IDLE.

Test Plan:
- Reset then start with default mask 8'h42, step_en=1 -> 8 valid rows idx 0..7, f=1 only at idx 1 and 6; done one cycle after row 7; ones_cnt=2; busy low after done.
- In IDLE, load with mask_in=8'hFF, then start -> all 8 rows f=1, ones_cnt=8 (no overflow); the next load with mask_in=8'h00 and a sweep give ones_cnt=0.
- Mid-sweep after row 3: toggle step_en low for 3 cycles -> valid=0 for 3 cycles, row 4 emitted after step_en returns, no row skipped or duplicated, total still 8 rows.
- During RUN, pulse start and load with mask_in=8'h00 -> ignored; sweep completes with mask 8'h42 and ones_cnt=2.
- Assert rst at row 5 -> all outputs 0 immediately, no done pulse; a new start replays from row 0.
- With TT_AUTOREPEAT_EN and repeat_en=1 -> two back-to-back sweeps, two done pulses 9 cycles apart, busy continuously high, ones_cnt resets to 0 and ends at 2 each time.

Source files
------------

// File: rtl/tt_sweeper.sv
// Sequential truth-table generator: sweeps all 2^N_IN input rows of a minterm-mask function.
// Optional macro TT_AUTOREPEAT_EN adds a repeat_en input that restarts the sweep straight from DONE.
module tt_sweeper #(
  parameter int                     N_IN     = 3,
  parameter logic [(1<<N_IN)-1:0]   MASK_RST = 8'h42
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  load,
  input  logic [(1<<N_IN)-1:0]  mask_in,
`ifdef TT_AUTOREPEAT_EN
  input  logic                  repeat_en,
`endif
  input  logic                  step_en,
  output logic [N_IN-1:0]       idx,
  output logic [N_IN-1:0]       x_vec,
  output logic                  f,
  output logic                  valid,
  output logic                  busy,
  output logic                  done,
  output logic [N_IN:0]         ones_cnt
);

  localparam int MW = 1 << N_IN;
  localparam logic [N_IN-1:0] PTR_MAX = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] PTR_ONE = N_IN'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [N_IN-1:0] ptr_r, ptr_s;
  logic [MW-1:0]   mask_r, mask_s;
  logic [N_IN-1:0] idx_r, idx_s;
  logic [N_IN-1:0] x_vec_r, x_vec_s;
  logic            f_r, f_s;
  logic            valid_r, valid_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic [N_IN:0]   ones_cnt_r, ones_cnt_s;

  // Next-state and next-output computation for the sweep FSM.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    mask_s     = mask_r;
    idx_s      = idx_r;
    x_vec_s    = x_vec_r;
    f_s        = f_r;
    valid_s    = 1'b0;
    busy_s     = busy_r;
    done_s     = 1'b0;
    ones_cnt_s = ones_cnt_r;
    case (state_r)
      ST_IDLE: begin
        // load lands on the same edge as start, so the new sweep sees the new mask
        if (load) begin
          mask_s = mask_in;
        end else begin
          mask_s = mask_r;
        end
        if (start) begin
          state_s    = ST_RUN;
          ptr_s      = '0;
          ones_cnt_s = '0;
          busy_s     = 1'b1;
        end else begin
          busy_s     = 1'b0;
        end
      end
      ST_RUN: begin
        if (step_en) begin
          valid_s    = 1'b1;
          idx_s      = ptr_r;
          x_vec_s    = ptr_r;
          f_s        = mask_r[ptr_r];
          ones_cnt_s = ones_cnt_r + {{N_IN{1'b0}}, mask_r[ptr_r]};
          if (ptr_r == PTR_MAX) begin
            state_s = ST_DONE;
            ptr_s   = '0;
          end else begin
            ptr_s   = ptr_r + PTR_ONE;
          end
        end else begin
          valid_s = 1'b0;
        end
      end
      ST_DONE: begin
        done_s = 1'b1;
`ifdef TT_AUTOREPEAT_EN
        if (repeat_en) begin
          state_s    = ST_RUN;
          ptr_s      = '0;
          ones_cnt_s = '0;
          busy_s     = 1'b1;
        end else begin
          state_s    = ST_IDLE;
          busy_s     = 1'b0;
        end
`else
        state_s = ST_IDLE;
        busy_s  = 1'b0;
`endif
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any sweep without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ptr_r      <= '0;
      mask_r     <= MASK_RST;
      idx_r      <= '0;
      x_vec_r    <= '0;
      f_r        <= 1'b0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ones_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      mask_r     <= mask_s;
      idx_r      <= idx_s;
      x_vec_r    <= x_vec_s;
      f_r        <= f_s;
      valid_r    <= valid_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      ones_cnt_r <= ones_cnt_s;
    end
  end

  assign idx      = idx_r;
  assign x_vec    = x_vec_r;
  assign f        = f_r;
  assign valid    = valid_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign ones_cnt = ones_cnt_r;

endmodule
